// File: rtl/radix_sequential_multiplicator_pkg.sv
// Shared types and constants for the radix sequential multiplier, its interface and bench.
package sequential_multiplicator_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int DEF_WIDTH          = 8;
  localparam int DEF_BITS_PER_CYCLE = 2;
  localparam int TB_WIDTH           = 8;
endpackage

// File: rtl/radix_sequential_multiplicator_if.sv
// Start/done handshake bundle between a requester and the radix multiplier.
interface radix_sequential_multiplicator_if
  import sequential_multiplicator_pkg::*;
#(
  parameter int WIDTH = TB_WIDTH
);
  logic               start_in;
  logic               signed_in;
  logic [WIDTH-1:0]   multiplicand_in;
  logic [WIDTH-1:0]   multiplier_in;
  logic [2*WIDTH-1:0] product_out;
  logic               overflow_out;
  logic               done_out;
  logic               busy_out;

  modport master (
    output start_in, signed_in, multiplicand_in, multiplier_in,
    input  product_out, overflow_out, done_out, busy_out
  );

  modport slave (
    input  start_in, signed_in, multiplicand_in, multiplier_in,
    output product_out, overflow_out, done_out, busy_out
  );
endinterface

// File: rtl/radix_sequential_multiplicator_step.sv
// One shift-add step: add mcand * low digit of the multiplier into the upper half, shift right.
module multiplicator_step #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mplier,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mplier
);
  localparam int PW = WIDTH + BITS_PER_CYCLE;
  localparam int DW = 2 * WIDTH;

  logic [PW-1:0] w_pp;
  logic [PW-1:0] w_sum;

  // acc + pp <= (2^W-1)*2^B, so PW bits never overflow
  assign w_pp  = PW'(i_mcand) * PW'(i_mplier[BITS_PER_CYCLE-1:0]);
  assign w_sum = PW'(i_acc) + w_pp;

  assign {o_acc, o_mplier} = DW'({w_sum, i_mplier} >> BITS_PER_CYCLE);
endmodule

// File: rtl/radix_sequential_multiplicator.sv
// Sequential signed/unsigned multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
module radix_sequential_multiplicator
  import sequential_multiplicator_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
  input logic                             clock,
  input logic                             reset_in,
  radix_sequential_multiplicator_if.slave bus
);
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("radix_sequential_multiplicator: WIDTH must be >= 2");
    end
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
      $error("radix_sequential_multiplicator: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end
  endgenerate

  mult_state_t        r_state, w_state_nxt;
  logic               r_signed, r_neg, r_overflow;
  logic [WIDTH-1:0]   r_mcand, r_mplier, r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic               w_start, w_last, w_ovf;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_acc_nxt, w_mplier_nxt;
  logic [2*WIDTH-1:0] w_prod_mag, w_prod;
  logic [WIDTH:0]     w_hi_s;

  assign w_start = bus.start_in && (r_state != CALC);
  assign w_last  = (r_state == CALC) && (r_cnt == CW'(1));

  // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude
  assign w_a_mag = (bus.signed_in && bus.multiplicand_in[WIDTH-1]) ? -bus.multiplicand_in
                                                                   : bus.multiplicand_in;
  assign w_b_mag = (bus.signed_in && bus.multiplier_in[WIDTH-1]) ? -bus.multiplier_in
                                                                 : bus.multiplier_in;

  multiplicator_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .i_mcand  (r_mcand),
    .i_acc    (r_acc),
    .i_mplier (r_mplier),
    .o_acc    (w_acc_nxt),
    .o_mplier (w_mplier_nxt)
  );

  assign w_prod_mag = {w_acc_nxt, w_mplier_nxt};
  assign w_prod     = r_neg ? -w_prod_mag : w_prod_mag;
  assign w_hi_s     = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_ovf      = r_signed ? !((w_hi_s == '0) || (&w_hi_s))
                               : (|w_prod[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clock) begin
    if (!reset_in) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (bus.start_in) w_state_nxt = CALC;
      CALC:       if (r_cnt == CW'(1)) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_in) begin
      r_signed   <= 1'b0;
      r_neg      <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_product  <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_signed <= bus.signed_in;
      r_neg    <= bus.signed_in & (bus.multiplicand_in[WIDTH-1] ^ bus.multiplier_in[WIDTH-1]);
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_cnt    <= CW'(STEPS);
    end else if (r_state == CALC) begin
      r_acc    <= w_acc_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= r_cnt - CW'(1);
      if (w_last) begin
        r_product  <= w_prod;
        r_overflow <= w_ovf;
      end
    end
  end

  assign bus.product_out  = r_product;
  assign bus.overflow_out = r_overflow;
  assign bus.done_out     = (r_state == DONE);
  assign bus.busy_out     = (r_state == CALC);
endmodule

// File: tb/tb_radix_sequential_multiplicator.sv
// Directed bench for radix_sequential_multiplicator at BITS_PER_CYCLE 2, 1 and 4.
module tb_radix_sequential_multiplicator;
  import sequential_multiplicator_pkg::*;

  localparam int W = TB_WIDTH;

  logic clk = 1'b0;
  logic reset_in;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  radix_sequential_multiplicator_if #(.WIDTH(W)) if2 ();
  radix_sequential_multiplicator_if #(.WIDTH(W)) if1 ();
  radix_sequential_multiplicator_if #(.WIDTH(W)) if4 ();

  radix_sequential_multiplicator #(.WIDTH(W), .BITS_PER_CYCLE(2)) u_b2 (
    .clock(clk), .reset_in(reset_in), .bus(if2.slave));
  radix_sequential_multiplicator #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_b1 (
    .clock(clk), .reset_in(reset_in), .bus(if1.slave));
  radix_sequential_multiplicator #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_b4 (
    .clock(clk), .reset_in(reset_in), .bus(if4.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic st, input logic sg,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    case (sel)
      1: begin if1.start_in = st; if1.signed_in = sg; if1.multiplicand_in = a; if1.multiplier_in = b; end
      4: begin if4.start_in = st; if4.signed_in = sg; if4.multiplicand_in = a; if4.multiplier_in = b; end
      default: begin if2.start_in = st; if2.signed_in = sg; if2.multiplicand_in = a; if2.multiplier_in = b; end
    endcase
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      1: return if1.done_out;
      4: return if4.done_out;
      default: return if2.done_out;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      1: return if1.busy_out;
      4: return if4.busy_out;
      default: return if2.busy_out;
    endcase
  endfunction

  function automatic logic [2*W-1:0] prod_of(input int sel);
    case (sel)
      1: return if1.product_out;
      4: return if4.product_out;
      default: return if2.product_out;
    endcase
  endfunction

  function automatic logic ovf_of(input int sel);
    case (sel)
      1: return if1.overflow_out;
      4: return if4.overflow_out;
      default: return if2.overflow_out;
    endcase
  endfunction

  // Start one operation and wait (bounded) for done; lat = -1 on timeout.
  task automatic run_op(input int sel, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic busy0, output logic done0);
    drive(sel, 1'b1, sg, a, b);
    tick();
    busy0 = busy_of(sel);
    done0 = done_of(sel);
    drive(sel, 1'b0, 1'b0, '0, '0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done_of(sel)) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    tick();
    tick();
    checks++; if (if2.product_out !== 16'h0000) begin errors++; $display("FAIL reset_product got %h exp 0000", if2.product_out); end
    checks++; if (if2.overflow_out !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", if2.overflow_out); end
    checks++; if (if2.done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", if2.done_out); end
    checks++; if (if2.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", if2.busy_out); end
    checks++; if ({if1.done_out, if1.busy_out, if4.done_out, if4.busy_out} !== 4'b0000) begin
      errors++; $display("FAIL reset_others got %b exp 0000", {if1.done_out, if1.busy_out, if4.done_out, if4.busy_out});
    end
    reset_in = 1'b1;
    tick();
  endtask

  task automatic test_unsigned();
    int lat; logic b0, d0;
    run_op(2, 1'b0, 8'd20, 8'd15, lat, b0, d0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL uns_busy_after_start got %b exp 1", b0); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL uns_latency got %0d exp 4", lat); end
    checks++; if (if2.product_out !== 16'h012C) begin errors++; $display("FAIL uns_product got %h exp 012c", if2.product_out); end
    checks++; if (if2.overflow_out !== 1'b1) begin errors++; $display("FAIL uns_overflow got %b exp 1", if2.overflow_out); end
    checks++; if (if2.busy_out !== 1'b0) begin errors++; $display("FAIL uns_busy_in_done got %b exp 0", if2.busy_out); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) tick();
    checks++; if (if2.done_out !== 1'b1) begin errors++; $display("FAIL hold_done got %b exp 1", if2.done_out); end
    checks++; if (if2.product_out !== 16'h012C) begin errors++; $display("FAIL hold_product got %h exp 012c", if2.product_out); end
  endtask

  task automatic test_signed();
    int lat; logic b0, d0;
    run_op(2, 1'b1, 8'hFD, 8'h05, lat, b0, d0);
    checks++; if (if2.product_out !== 16'hFFF1) begin errors++; $display("FAIL sgn_m3x5_product got %h exp fff1", if2.product_out); end
    checks++; if (if2.overflow_out !== 1'b0) begin errors++; $display("FAIL sgn_m3x5_overflow got %b exp 0", if2.overflow_out); end
    run_op(2, 1'b1, 8'h80, 8'h80, lat, b0, d0);
    checks++; if (if2.product_out !== 16'h4000) begin errors++; $display("FAIL sgn_m128sq_product got %h exp 4000", if2.product_out); end
    checks++; if (if2.overflow_out !== 1'b1) begin errors++; $display("FAIL sgn_m128sq_overflow got %b exp 1", if2.overflow_out); end
    run_op(2, 1'b1, 8'h80, 8'h01, lat, b0, d0);
    checks++; if (if2.product_out !== 16'hFF80) begin errors++; $display("FAIL sgn_m128x1_product got %h exp ff80", if2.product_out); end
    checks++; if (if2.overflow_out !== 1'b0) begin errors++; $display("FAIL sgn_m128x1_overflow got %b exp 0", if2.overflow_out); end
  endtask

  task automatic test_back_to_back();
    int lat; logic b0, d0;
    run_op(2, 1'b0, 8'd7, 8'd9, lat, b0, d0);
    checks++; if (if2.product_out !== 16'h003F) begin errors++; $display("FAIL b2b_first_product got %h exp 003f", if2.product_out); end
    // start on the first edge spent in DONE
    run_op(2, 1'b1, 8'hFE, 8'hFD, lat, b0, d0);
    checks++; if (d0 !== 1'b0 || b0 !== 1'b1) begin errors++; $display("FAIL b2b_restart got done %b busy %b exp done 0 busy 1", d0, b0); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", lat); end
    checks++; if (if2.product_out !== 16'h0006) begin errors++; $display("FAIL b2b_second_product got %h exp 0006", if2.product_out); end
  endtask

  task automatic test_radix();
    int lat; logic b0, d0;
    run_op(1, 1'b0, 8'd255, 8'd255, lat, b0, d0);
    checks++; if (lat !== 8) begin errors++; $display("FAIL r1_latency got %0d exp 8", lat); end
    checks++; if (if1.product_out !== 16'hFE01) begin errors++; $display("FAIL r1_product got %h exp fe01", if1.product_out); end
    checks++; if (if1.overflow_out !== 1'b1) begin errors++; $display("FAIL r1_overflow got %b exp 1", if1.overflow_out); end
    run_op(4, 1'b0, 8'd255, 8'd255, lat, b0, d0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL r4_latency got %0d exp 2", lat); end
    checks++; if (if4.product_out !== 16'hFE01) begin errors++; $display("FAIL r4_product got %h exp fe01", if4.product_out); end
    checks++; if (if4.overflow_out !== 1'b1) begin errors++; $display("FAIL r4_overflow got %b exp 1", if4.overflow_out); end
    run_op(4, 1'b1, 8'hFD, 8'h05, lat, b0, d0);
    checks++; if (if4.product_out !== 16'hFFF1) begin errors++; $display("FAIL r4_signed_product got %h exp fff1", if4.product_out); end
  endtask

  task automatic test_start_ignored();
    int lat;
    drive(2, 1'b1, 1'b0, 8'd20, 8'd15);
    tick();
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    drive(2, 1'b1, 1'b0, 8'd7, 8'd3);
    tick();
    drive(2, 1'b0, 1'b0, '0, '0);
    lat = -1;
    for (int c = 3; c <= 20; c++) begin
      tick();
      if (if2.done_out) begin
        lat = c;
        break;
      end
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ign_latency got %0d exp 4", lat); end
    checks++; if (if2.product_out !== 16'h012C) begin errors++; $display("FAIL ign_product got %h exp 012c", if2.product_out); end
    tick();
    checks++; if (if2.done_out !== 1'b1) begin errors++; $display("FAIL ign_no_restart got done %b exp 1", if2.done_out); end
  endtask

  task automatic test_reset_mid();
    int lat; logic b0, d0; logic seen;
    drive(2, 1'b1, 1'b1, 8'hFD, 8'h05);
    tick();
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    reset_in = 1'b0;
    tick();
    reset_in = 1'b1;
    checks++; if ({if2.product_out, if2.overflow_out, if2.done_out, if2.busy_out} !== 19'h0) begin
      errors++; $display("FAIL rstmid_outputs got prod %h ovf %b done %b busy %b exp all 0",
                         if2.product_out, if2.overflow_out, if2.done_out, if2.busy_out);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if2.done_out || if2.busy_out) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got %b exp 0", seen); end
    run_op(2, 1'b0, 8'd20, 8'd15, lat, b0, d0);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_restart_latency got %0d exp 4", lat); end
    checks++; if (if2.product_out !== 16'h012C) begin errors++; $display("FAIL rstmid_restart_product got %h exp 012c", if2.product_out); end
  endtask

  task automatic test_start_with_reset();
    reset_in = 1'b0;
    drive(2, 1'b1, 1'b0, 8'd20, 8'd15);
    tick();
    checks++; if (if2.busy_out !== 1'b0 || if2.done_out !== 1'b0) begin
      errors++; $display("FAIL startrst_edge got busy %b done %b exp 0 0", if2.busy_out, if2.done_out);
    end
    reset_in = 1'b1;
    drive(2, 1'b0, 1'b0, '0, '0);
    tick();
    checks++; if (if2.busy_out !== 1'b0 || if2.product_out !== 16'h0000) begin
      errors++; $display("FAIL startrst_idle got busy %b prod %h exp 0 0000", if2.busy_out, if2.product_out);
    end
  endtask

  initial begin
    reset_in = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    drive(4, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_unsigned();
    test_hold();
    test_signed();
    test_back_to_back();
    test_radix();
    test_start_ignored();
    test_reset_mid();
    test_start_with_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/radix_sequential_multiplicator.md
# radix_sequential_multiplicator

Parametrised sequential shift-add multiplier that replaces the fixed-width, unsigned-only sequential multiplicator. It retires `BITS_PER_CYCLE` multiplier bits per clock and supports a per-operation signed/unsigned mode. It adds a `busy_out` status flag and holds its result stable until the next accepted start. It sits on the same start/done handshake used by the existing multiplicator benches.

## Interface

Parameters:
- `WIDTH`, default 8: operand width. Must be ≥ 2.
- `BITS_PER_CYCLE`, default 2: multiplier bits consumed per step. Legal values are 1, 2 or 4, and the value must divide `WIDTH`.
- `STEPS`, derived as `WIDTH/BITS_PER_CYCLE`: number of compute cycles.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset_in`  in  1: reset, synchronous and active-low.
- `start_in`  in  1: start request; sampled only in IDLE or DONE.
- `signed_in`  in  1: 1 = two's-complement operands, 0 = unsigned. Sampled together with `start_in`.
- `multiplicand_in`  in  WIDTH: multiplicand; sampled at the start edge.
- `multiplier_in`  in  WIDTH: multiplier; sampled at the start edge.
- `product_out`  out  2*WIDTH: registered result; held until the next accepted start.
- `overflow_out`  out  1: result not representable in WIDTH bits for the sampled mode.
- `done_out`  out  1: result valid; level signal, high in DONE.
- `busy_out`  out  1: high in CALC.

## Operation

- The FSM has three states: IDLE, CALC and DONE.
- IDLE, `start_in`=1:
  - Latch the mode.
  - Latch the operand magnitudes: the absolute value when signed, the raw value otherwise.
  - Latch the result sign as the XOR of the operand MSBs, signed mode only.
  - Clear the accumulator, load the step counter with `STEPS`, and go to CALC.
- CALC, each edge:
  - Compute the partial product as multiplicand magnitude × low `BITS_PER_CYCLE` bits of the multiplier register. This is a (WIDTH+BITS_PER_CYCLE)-bit value.
  - Add the partial product to the upper accumulator half.
  - Shift the {accumulator, multiplier} register right by `BITS_PER_CYCLE`.
  - Decrement the counter.
- CALC, on the edge where the counter reaches 0:
  - Write `product_out` with the accumulated product, negated if the result sign is 1.
  - Write `overflow_out` and go to DONE.
- DONE:
  - Hold all outputs.
  - `start_in`=1 is accepted exactly as in IDLE, and `done_out` falls on that edge.
- `start_in` in CALC is ignored. There is no queueing and no abort.
- Overflow rule:
  - Unsigned mode: `product_out[2W-1:W]` ≠ 0.
  - Signed mode: `product_out[2W-1:W-1]` is not all-zeros and not all-ones.
- Magnitude of −2^(W−1) is 2^(W−1). This fits in a W-bit unsigned register, so no special case is needed.
- A zero operand still takes the full `STEPS` cycles. There is no early termination.

## Timing

- Start sampled at edge k:
  - `busy_out`=1 after edge k.
  - `done_out`=1 and the result is valid after edge k+STEPS. Latency is STEPS cycles, giving 4 cycles for the defaults.
- Back-to-back throughput: a start at the first DONE edge gives one result per STEPS+1 cycles.
- Reset (`reset_in`=0 at an edge):
  - Outputs after that edge: state IDLE, `product_out`=0, `overflow_out`=0, `done_out`=0, `busy_out`=0.
  - Reset has priority over a simultaneous `start_in`.
  - Reset mid-CALC discards the operation, and no `done_out` is produced.
- `done_out` and `busy_out` are never high simultaneously.

## Structure

- Shared package `sequential_multiplicator_pkg` holds:
  - the `mult_state_t` enum {IDLE, CALC, DONE};
  - default `WIDTH`/`BITS_PER_CYCLE` constants;
  - the bench's WIDTH constant, so the interface and the DUT agree.
- One sub-module, `multiplicator_step`: combinational partial product and accumulate-shift for one step, parametrised by `WIDTH` and `BITS_PER_CYCLE`.
- The top level holds the FSM, counter, operand/sign registers, sign fix-up and overflow logic.
- Legal parameter combinations are checked at elaboration with `$error`.

## Test plan

- WIDTH=8, BITS_PER_CYCLE=2, unsigned, 20×15 → `product_out`=16'h012C, `overflow_out`=1, `done_out` exactly 4 cycles after the start edge.
- Signed, −3×5 (8'hFD, 8'h05) → 16'hFFF1, `overflow_out`=0.
- Signed, −128×−128 → 16'h4000, `overflow_out`=1. Signed, −128×1 → 16'hFF80, `overflow_out`=0.
- BITS_PER_CYCLE=1, unsigned, 255×255 → 16'hFE01, `overflow_out`=1, latency 8 cycles. Repeat with BITS_PER_CYCLE=4: same result, latency 2.
- `start_in` pulsed again 2 cycles into CALC with different operands → ignored; the first result is delivered on schedule.
- `reset_in` low for one edge during CALC → all outputs 0, no `done_out`. A start on the next edge completes normally. Start and reset asserted at the same edge → stays IDLE.
